// File: rtl/cam_pkg.sv
// Shared types for the DVP capture block: RGB565 pixel, capture FSM states and
// the 37-bit pixel FIFO word {sof,eol,y,x,data}.
package cam_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int PIX_WORD_W   = 37;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic           sof;
        logic           eol;
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x;
        rgb565_t        data;
    } pix_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VS_HI,
        ST_WAIT_VS_LO,
        ST_ACTIVE,
        ST_END
    } cam_state_e;

    // The camera sends the high byte first; the two bytes map straight onto RGB565.
    function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return rgb565_t'({hi, lo});
    endfunction

endpackage

// File: rtl/cam_pix_fifo.sv
// First-word-fall-through pixel FIFO, DEPTH x 37 bits. A write while full is
// accepted when a read frees the slot in the same cycle.
module cam_pix_fifo
    import cam_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      wr_en_i,
    input  pix_word_t wr_word_i,
    input  logic      rd_en_i,
    output pix_word_t rd_word_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIX_WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;
    logic [AW:0]           count_d;
    logic                  wr_acc;
    logic                  rd_acc;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign rd_acc    = rd_en_i && !empty_o;
    assign wr_acc    = wr_en_i && (!full_o || rd_acc);
    assign rd_word_o = pix_word_t'(mem_q[rd_ptr_q]);

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_word_i;
    end

endmodule

// File: rtl/cam_dvp_capture.sv
// OV7670 DVP capture: oversampled PCLK/VSYNC/HREF/D, byte pairing into RGB565 with
// x/y tagging, frame status and a ready/valid pixel FIFO. CAM_CAPTURE_STATS_EN adds frame_cnt/err_cnt.
module cam_dvp_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_done,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_d,
    output logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_done,
    output logic        frame_err,
    output logic        ovf_sticky
`ifdef CAM_CAPTURE_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);
    localparam int             NPIX   = H_ACTIVE * V_ACTIVE;
    localparam int             CNT_W  = $clog2(NPIX + 1);

    logic [10:0]      sync1_q;
    logic [10:0]      sync2_q;
    logic             pclk_q;
    logic             href_q;
    logic             vsync_q;
    logic [7:0]       byte_q;
    logic             pclk_rise_q;
    logic             href_rise_q;
    logic             href_fall_q;
    logic             vs_rise_q;

    cam_state_e       state_q, state_d;
    logic             phase_q, phase_d;
    logic [7:0]       hi_q, hi_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             full_q, full_d;
    logic             line_err_q, line_err_d;
    logic             ovf_frame_q, ovf_frame_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic             ovf_sticky_q;

    logic             active;
    logic             byte_ev;
    logic             phase_now;
    logic             wr_req;
    logic             rd_en;
    logic             fifo_wr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ovf;
    logic             frame_bad;
    pix_word_t        wr_word;
    pix_word_t        rd_word;

    // Two-flop synchroniser for {pclk, vsync, href, d}.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {cam_pclk, cam_vsync, cam_href, cam_d};
            sync2_q <= sync1_q;
        end
    end

    // Edge events are registered so levels and events line up in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pclk_q      <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            byte_q      <= '0;
            pclk_rise_q <= 1'b0;
            href_rise_q <= 1'b0;
            href_fall_q <= 1'b0;
            vs_rise_q   <= 1'b0;
        end else begin
            pclk_q      <= sync2_q[10];
            vsync_q     <= sync2_q[9];
            href_q      <= sync2_q[8];
            byte_q      <= sync2_q[7:0];
            pclk_rise_q <= sync2_q[10] & ~pclk_q;
            vs_rise_q   <= sync2_q[9] & ~vsync_q;
            href_rise_q <= sync2_q[8] & ~href_q;
            href_fall_q <= ~sync2_q[8] & href_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (cfg_done)   state_d = ST_WAIT_VS_HI;
            ST_WAIT_VS_HI: if (vsync_q)    state_d = ST_WAIT_VS_LO;
            ST_WAIT_VS_LO: if (!vsync_q)   state_d = ST_ACTIVE;
            ST_ACTIVE:     if (vs_rise_q)  state_d = ST_END;
            ST_END:                        state_d = ST_WAIT_VS_LO;
            default:                       state_d = ST_IDLE;
        endcase
        if (!cfg_done) state_d = ST_IDLE;
    end

    assign active    = (state_q == ST_ACTIVE);
    assign byte_ev   = active && pclk_rise_q && href_q;
    assign phase_now = href_rise_q ? 1'b0 : phase_q;
    assign wr_req    = byte_ev && phase_now && !full_q;
    assign rd_en     = pix_valid && pix_ready;
    assign fifo_wr   = wr_req && (!fifo_full || rd_en);
    assign ovf       = wr_req && fifo_full && !rd_en;

    always_comb begin
        wr_word.sof  = (x_q == '0) && (y_q == '0);
        wr_word.eol  = (x_q == X_LAST);
        wr_word.y    = y_q;
        wr_word.x    = x_q;
        wr_word.data = pack_rgb565(hi_q, byte_q);
    end

    always_comb begin
        phase_d     = phase_q;
        hi_d        = hi_q;
        x_d         = x_q;
        y_d         = y_q;
        full_d      = full_q;
        line_err_d  = line_err_q;
        ovf_frame_d = ovf_frame_q;
        pix_cnt_d   = pix_cnt_q;
        if (!active) begin
            phase_d     = 1'b0;
            x_d         = '0;
            y_d         = '0;
            full_d      = 1'b0;
            line_err_d  = 1'b0;
            ovf_frame_d = 1'b0;
            pix_cnt_d   = '0;
        end else begin
            if (href_rise_q) phase_d = 1'b0;
            if (href_fall_q && phase_q) begin
                phase_d    = 1'b0;
                line_err_d = 1'b1;
            end
            if (byte_ev) begin
                if (!phase_now) begin
                    hi_d    = byte_q;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (full_q) begin
                        line_err_d = 1'b1;
                    end else begin
                        // Geometry advances even when the FIFO drops the pixel.
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            if (y_q == Y_LAST) full_d = 1'b1;
                            else               y_d    = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
            end
            if (ovf) ovf_frame_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            full_q       <= 1'b0;
            line_err_q   <= 1'b0;
            ovf_frame_q  <= 1'b0;
            pix_cnt_q    <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            x_q          <= x_d;
            y_q          <= y_d;
            full_q       <= full_d;
            line_err_q   <= line_err_d;
            ovf_frame_q  <= ovf_frame_d;
            pix_cnt_q    <= pix_cnt_d;
            if (ovf) ovf_sticky_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        hi_q <= hi_d;
    end

    assign frame_bad  = line_err_q || ovf_frame_q || (pix_cnt_q != CNT_W'(NPIX));
    assign frame_done = (state_q == ST_END);
    assign frame_err  = (state_q == ST_END) && frame_bad;
    assign ovf_sticky = ovf_sticky_q;

    cam_pix_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (fifo_wr),
        .wr_word_i (wr_word),
        .rd_en_i   (rd_en),
        .rd_word_o (rd_word),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Outputs are forced to zero when no pixel is offered.
    assign pix_valid = !fifo_empty;
    assign pix_data  = pix_valid ? rd_word.data : '0;
    assign pix_x     = pix_valid ? rd_word.x    : '0;
    assign pix_y     = pix_valid ? rd_word.y    : '0;
    assign pix_sof   = pix_valid && rd_word.sof;
    assign pix_eol   = pix_valid && rd_word.eol;

`ifdef CAM_CAPTURE_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (state_q == ST_END) begin
            if (!frame_bad)                frame_cnt_q <= frame_cnt_q + 1'b1;
            else if (err_cnt_q != 16'hFFFF) err_cnt_q  <= err_cnt_q + 1'b1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    // Frame statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_cam_dvp_capture.sv
// Directed bench for cam_dvp_capture with a 4x2 frame and a 4-entry pixel FIFO.
module tb_cam_dvp_capture;

    logic        clk;
    logic        reset;
    logic        cfg_done;
    logic        cam_pclk;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_d;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_valid;
    logic        pix_ready;
    logic        frame_done;
    logic        frame_err;
    logic        ovf_sticky;
`ifdef CAM_CAPTURE_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int done_err_cnt = 0;
    logic last_err = 1'b0;
    logic [36:0] got_q[$];
    logic [7:0] line_bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    cam_dvp_capture #(
        .H_ACTIVE   (4),
        .V_ACTIVE   (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_done   (cfg_done),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_d      (cam_d),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .ovf_sticky (ovf_sticky)
`ifdef CAM_CAPTURE_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (pix_valid && pix_ready) got_q.push_back({pix_sof, pix_eol, pix_y, pix_x, pix_data});
        if (frame_done) begin
            done_cnt++;
            last_err = frame_err;
            if (frame_err) done_err_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pclk_cycle();
        cam_pclk = 1'b0;
        clks(3);
        cam_pclk = 1'b1;
        clks(3);
    endtask

    task automatic send_line(input int nbytes);
        for (int j = 0; j < nbytes; j++) begin
            cam_pclk = 1'b0;
            cam_href = 1'b1;
            cam_d    = line_bytes[j];
            clks(3);
            cam_pclk = 1'b1;
            clks(3);
        end
        cam_href = 1'b0;
        pclk_cycle();
        pclk_cycle();
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        repeat (3) pclk_cycle();
        cam_vsync = 1'b0;
        repeat (3) pclk_cycle();
    endtask

    task automatic send_frame(input int n0, input int n1);
        send_line(n0);
        send_line(n1);
        vsync_pulse();
        clks(10);
    endtask

    // Expected FIFO word for frame position pos carrying the k-th byte pair of its line.
    function automatic logic [36:0] exp_word(input int pos, input int k);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = line_bytes[2*k];
        lo = line_bytes[2*k+1];
        return {(pos == 0), ((pos % 4) == 3), 9'(pos / 4), 10'(pos % 4), hi, lo};
    endfunction

    task automatic chk_pix(input string tag, input int idx, input logic [36:0] exp);
        logic [36:0] obs;
        obs = (idx < got_q.size()) ? got_q[idx] : 37'h0;
        chk($sformatf("%s[%0d]", tag, idx), 64'(obs), 64'(exp));
    endtask

    initial begin
        reset     = 1'b1;
        cfg_done  = 1'b0;
        cam_pclk  = 1'b0;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_d     = 8'h00;
        pix_ready = 1'b1;
        clks(5);
        chk("rst_valid", 64'(pix_valid), 64'd0);
        chk("rst_data", 64'(pix_data), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_err", 64'(frame_err), 64'd0);
        chk("rst_ovf", 64'(ovf_sticky), 64'd0);
        reset = 1'b0;
        clks(3);

        // No capture while configuration is pending.
        vsync_pulse();
        send_frame(8, 8);
        chk("t1_done", 64'(done_cnt), 64'd0);
        chk("t1_pix", 64'(got_q.size()), 64'd0);
        chk("t1_valid", 64'(pix_valid), 64'd0);

        // Clean 4x2 frame.
        cfg_done = 1'b1;
        clks(4);
        vsync_pulse();
        send_frame(8, 8);
        chk("t2_done", 64'(done_cnt), 64'd1);
        chk("t2_err", 64'(last_err), 64'd0);
        chk("t2_npix", 64'(got_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) chk_pix("t2_pix", i, exp_word(i, i % 4));

        // Odd byte count on line 0: 7th byte discarded, geometry continues by pixel count.
        got_q.delete();
        send_frame(7, 8);
        chk("t3_done", 64'(done_cnt), 64'd2);
        chk("t3_err", 64'(last_err), 64'd1);
        chk("t3_npix", 64'(got_q.size()), 64'd7);
        for (int i = 0; i < 3; i++) chk_pix("t3_pix", i, exp_word(i, i));
        for (int k = 0; k < 4; k++) chk_pix("t3_pix", 3 + k, exp_word(3 + k, k));

        // Back-pressure for a whole frame: FIFO holds the 4 oldest pixels.
        got_q.delete();
        pix_ready = 1'b0;
        send_frame(8, 8);
        chk("t4_done", 64'(done_cnt), 64'd3);
        chk("t4_err", 64'(last_err), 64'd1);
        chk("t4_ovf", 64'(ovf_sticky), 64'd1);
        chk("t4_valid", 64'(pix_valid), 64'd1);
        chk("t4_head", 64'({pix_sof, pix_eol, pix_y, pix_x, pix_data}), 64'(exp_word(0, 0)));
        clks(7);
        chk("t4_hold", 64'({pix_sof, pix_eol, pix_y, pix_x, pix_data}), 64'(exp_word(0, 0)));
        chk("t4_npix0", 64'(got_q.size()), 64'd0);
        pix_ready = 1'b1;
        clks(20);
        chk("t4_npix", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk_pix("t4_pix", i, exp_word(i, i));
        chk("t4_empty", 64'(pix_valid), 64'd0);

        // cfg_done drop mid-frame discards it; the next full frame is clean.
        got_q.delete();
        send_line(8);
        cfg_done = 1'b0;
        clks(4);
        send_line(8);
        vsync_pulse();
        clks(10);
        chk("t5_nodone", 64'(done_cnt), 64'd3);
        chk("t5_partial", 64'(got_q.size()), 64'd4);
        cfg_done = 1'b1;
        clks(4);
        vsync_pulse();
        send_frame(8, 8);
        chk("t5_done", 64'(done_cnt), 64'd4);
        chk("t5_err", 64'(last_err), 64'd0);
        chk("t5_ovf_kept", 64'(ovf_sticky), 64'd1);
        chk("t5_npix", 64'(got_q.size()), 64'd12);
        chk_pix("t5_pix", 4, exp_word(0, 0));
        chk_pix("t5_pix", 11, exp_word(7, 3));

        // Reset clears sticky state; then 3 good frames and 1 bad one.
        reset = 1'b1;
        clks(3);
        reset = 1'b0;
        chk("t6_ovf_rst", 64'(ovf_sticky), 64'd0);
`ifdef CAM_CAPTURE_STATS_EN
        chk("t6_fcnt_rst", 64'(frame_cnt), 64'd0);
        chk("t6_ecnt_rst", 64'(err_cnt), 64'd0);
`endif
        clks(4);
        vsync_pulse();
        send_frame(8, 8);
        send_frame(8, 8);
        send_frame(8, 8);
        send_frame(7, 8);
        chk("t6_done", 64'(done_cnt), 64'd8);
        chk("t6_errs", 64'(done_err_cnt), 64'd3);
`ifdef CAM_CAPTURE_STATS_EN
        chk("t6_fcnt", 64'(frame_cnt), 64'd3);
        chk("t6_ecnt", 64'(err_cnt), 64'd1);
        reset = 1'b1;
        clks(2);
        chk("t6_fcnt_rst2", 64'(frame_cnt), 64'd0);
        chk("t6_ecnt_rst2", 64'(err_cnt), 64'd0);
        reset = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish within 1 ms");
        $fatal(1);
    end

endmodule
